// File: rtl/nanci_pe_loader.sv
// Host-stream loader: writes {key, data} words into PE memory addresses 0..WORDS-1
// through a small elastic FIFO, then holds done until the next start.
module nanci_pe_loader #(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned DATA_WIDTH = 3,
  parameter int unsigned WORDS      = 4,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] s_word,
  output logic                           mem_we,
  output logic [ADDR_WIDTH-1:0]          mem_addr,
  output logic [ADDR_WIDTH+DATA_WIDTH-1:0] mem_wdata,
  output logic                           busy,
  output logic                           done,
  output logic [ADDR_WIDTH:0]            count
);

  localparam int unsigned WW = ADDR_WIDTH + DATA_WIDTH;
  localparam int unsigned CW = ADDR_WIDTH + 1;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned OW = PW + 1;
  localparam logic [CW-1:0] WORDS_C = CW'(WORDS);
  localparam logic [OW-1:0] DEPTH_C = OW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t        state_q, state_d;
  logic [WW-1:0] fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [OW-1:0] occ_q, occ_d;
  logic [CW-1:0] accepted_q, accepted_d;

  logic push_c, pop_c, clear_c, ready_d;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state plus next-cycle occupancy/ready, so s_ready is a registered output
  always_comb begin
    state_d    = state_q;
    clear_c    = 1'b0;
    push_c     = (state_q == LOAD) && s_valid && s_ready;
    pop_c      = (state_q == LOAD) && (occ_q != '0) && (count < WORDS_C);
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = LOAD;
          clear_c = 1'b1;
        end
      end
      LOAD: begin
        if (pop_c && (count + CW'(1) == WORDS_C)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    occ_d      = clear_c ? '0 : occ_q + OW'(push_c) - OW'(pop_c);
    accepted_d = clear_c ? '0 : accepted_q + CW'(push_c);
    ready_d    = (state_d == LOAD) && (occ_d < DEPTH_C) && (accepted_d < WORDS_C);
  end

  // FIFO, counters and registered memory write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) fifo_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      accepted_q <= '0;
      count      <= '0;
      s_ready    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      s_ready    <= ready_d;
      busy       <= (state_d == LOAD);
      done       <= (state_d == DONE);
      occ_q      <= occ_d;
      accepted_q <= accepted_d;
      mem_we     <= pop_c;
      if (clear_c) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count    <= '0;
      end else begin
        if (push_c) begin
          fifo_q[wr_ptr_q] <= s_word;
          wr_ptr_q         <= wr_ptr_q + PW'(1);
        end
        if (pop_c) begin
          mem_addr  <= count[ADDR_WIDTH-1:0];
          mem_wdata <= fifo_q[rd_ptr_q];
          rd_ptr_q  <= rd_ptr_q + PW'(1);
          count     <= count + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_nanci_pe_loader.sv
// Directed self-checking bench for nanci_pe_loader (ADDR_WIDTH=DATA_WIDTH=3, WORDS=4).
module tb_nanci_pe_loader;

  logic       clk, rst_n, start, s_valid, s_ready;
  logic [5:0] s_word;
  logic       mem_we, busy, done;
  logic [2:0] mem_addr;
  logic [5:0] mem_wdata;
  logic [3:0] count;

  nanci_pe_loader #(
    .ADDR_WIDTH(3), .DATA_WIDTH(3), .WORDS(4), .FIFO_DEPTH(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid),
    .s_ready(s_ready), .s_word(s_word), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
    .done(done), .count(count)
  );

  int tests = 0;
  int fails = 0;

  int         cyc = 0;
  int         wr_n = 0;
  logic [2:0] wr_addr [64];
  logic [5:0] wr_data [64];
  int         wr_cyc  [64];
  int         xfer_cyc [4];
  logic [5:0] words [4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write monitor: samples 1 time unit after each rising edge
  always begin
    @(posedge clk);
    #1;
    cyc = cyc + 1;
    if (mem_we && wr_n < 64) begin
      wr_addr[wr_n] = mem_addr;
      wr_data[wr_n] = mem_wdata;
      wr_cyc[wr_n]  = cyc;
      wr_n = wr_n + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the following negedge with the block in LOAD
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_count_clear", 32'(count), 0);
    check("start_busy", 32'(busy), 1);
    check("start_done", 32'(done), 0);
  endtask

  task automatic run_load(input logic [6:0] pat, input int npat, input int extra, input bit mid_start);
    int idx = 0;
    int step = 0;
    int guard = 0;
    int base;
    int bad = 0;
    bit mid_done = 1'b0;
    base = wr_n;
    pulse_start();
    while (idx < 4 && guard < 100) begin
      s_valid = (step < npat) ? pat[step] : 1'b1;
      s_word  = words[idx];
      start   = 1'b0;
      if (mid_start && idx == 2 && !mid_done) begin
        start = 1'b1;
        mid_done = 1'b1;
      end
      if (s_valid && s_ready) begin
        xfer_cyc[idx] = cyc + 1;
        idx++;
      end
      step++;
      guard++;
      @(negedge clk);
    end
    start = 1'b0;
    if (guard >= 100) check("xfer_timeout", 32'(idx), 4);
    s_valid = 1'b1;
    for (int i = 0; i < extra; i++) begin
      if (s_ready) bad++;
      @(negedge clk);
    end
    s_valid = 1'b0;
    check("ready_low_after_full", 32'(bad), 0);
    guard = 0;
    while (!done && guard < 20) begin
      guard++;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    check("run_done", 32'(done), 1);
    check("run_busy", 32'(busy), 0);
    check("run_count", 32'(count), 4);
    check("run_nwrites", 32'(wr_n - base), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("wr%0d_addr", i), 32'(wr_addr[base + i]), 32'(i));
      check($sformatf("wr%0d_data", i), 32'(wr_data[base + i]), 32'(words[i]));
      check($sformatf("wr%0d_latency", i), 32'(wr_cyc[base + i]), 32'(xfer_cyc[i] + 1));
    end
  endtask

  initial begin
    int bad;
    int guard;
    int base;
    rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_word = '0;
    #23;
    check("rst_s_ready", 32'(s_ready), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_count", 32'(count), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_wdata", 32'(mem_wdata), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // s_valid without start: nothing moves
    base = wr_n;
    bad = 0;
    s_valid = 1'b1; s_word = 6'o77;
    repeat (10) begin
      @(negedge clk);
      if (s_ready || mem_we || busy || done) bad++;
    end
    s_valid = 1'b0;
    check("idle_gating", 32'(bad), 0);
    check("idle_nwrites", 32'(wr_n - base), 0);

    // Basic back-to-back load with trailing valid (backpressure)
    words[0] = 6'o04; words[1] = 6'o13; words[2] = 6'o22; words[3] = 6'o31;
    run_load(7'b1111111, 7, 6, 1'b0);

    // Restart from DONE with bursty valid 1,0,0,1,1,0,1
    words[0] = 6'o55; words[1] = 6'o66; words[2] = 6'o70; words[3] = 6'o07;
    run_load(7'b1011001, 7, 0, 1'b0);

    // start during LOAD after two words is ignored
    words[0] = 6'o11; words[1] = 6'o23; words[2] = 6'o35; words[3] = 6'o47;
    run_load(7'b1111111, 7, 2, 1'b1);

    // Asynchronous reset between edges after two writes
    base = wr_n;
    pulse_start();
    s_valid = 1'b1; s_word = 6'o45;
    guard = 0;
    while ((wr_n - base) < 2 && guard < 20) begin
      guard++;
      @(negedge clk);
    end
    check("pre_reset_writes", 32'(wr_n - base), 2);
    check("pre_reset_we", 32'(mem_we), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_mem_we", 32'(mem_we), 0);
    check("async_busy", 32'(busy), 0);
    check("async_done", 32'(done), 0);
    check("async_count", 32'(count), 0);
    check("async_s_ready", 32'(s_ready), 0);
    s_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    words[0] = 6'o12; words[1] = 6'o34; words[2] = 6'o56; words[3] = 6'o70;
    run_load(7'b1111111, 7, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
